// File: rtl/wbu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wbu_pipe
// Purpose  : Handshaked in-order writeback queue feeding the register file,
//            with optional commit bypass to the IDU read ports.
// Revision : 1.0 - initial release
// ============================================================================
module wbu_pipe #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_alu,
    input  logic [XLEN-1:0] in_lsu,
    input  logic [XLEN-1:0] in_csr,
    input  logic [1:0]      in_sel,
    input  logic            in_wen,
    input  logic [AW-1:0]   in_rd,
    input  logic            hold,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            retire,
    output logic [63:0]     retire_cnt
);

    localparam int c_pw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_pw-1:0] c_last  = c_pw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    logic [XLEN-1:0]  r_data_q [DEPTH];
    logic             r_wen_q  [DEPTH];
    logic [AW-1:0]    r_rd_q   [DEPTH];
    logic [DEPTH-1:0] r_vld_q, w_vld_d;
    logic [c_pw-1:0]  r_head_q, w_head_d;
    logic [c_pw-1:0]  r_tail_q, w_tail_d;
    logic [c_cw-1:0]  r_count_q, w_count_d;
    logic             r_retire_q, w_retire_d;
    logic [63:0]      r_retire_cnt_q, w_retire_cnt_d;
    logic [XLEN-1:0]  r_rf_q [NREG];

    logic             w_push;
    logic             w_commit;
    logic [XLEN-1:0]  w_sel_data;
    logic [XLEN-1:0]  w_head_data;
    logic             w_head_wen;
    logic [AW-1:0]    w_head_rd;
    logic             w_byp1;
    logic             w_byp2;

    function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    // Ready looks only at registered occupancy, never at this cycle's pop.
    assign in_ready    = (r_count_q < c_depth);
    assign w_push      = in_valid && in_ready;
    assign w_commit    = (r_count_q != '0) && !hold;
    assign w_head_data = r_data_q[r_head_q];
    assign w_head_wen  = r_wen_q[r_head_q];
    assign w_head_rd   = r_rd_q[r_head_q];

    always_comb begin
        w_sel_data = in_alu;
        unique case (in_sel)
            2'b01:   w_sel_data = in_lsu;
            2'b10:   w_sel_data = in_csr;
            default: w_sel_data = in_alu;
        endcase
    end

    assign w_byp1 = (BYPASS != 0) && w_commit && w_head_wen &&
                    (w_head_rd == rs1_addr) && (rs1_addr != '0);
    assign w_byp2 = (BYPASS != 0) && w_commit && w_head_wen &&
                    (w_head_rd == rs2_addr) && (rs2_addr != '0);

    assign rs1_data = (rs1_addr == '0) ? '0 : (w_byp1 ? w_head_data : r_rf_q[rs1_addr]);
    assign rs2_data = (rs2_addr == '0) ? '0 : (w_byp2 ? w_head_data : r_rf_q[rs2_addr]);

    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld_q[i] && r_wen_q[i]) begin
                if ((r_rd_q[i] == rs1_addr) && (rs1_addr != '0) &&
                    !(w_byp1 && (c_pw'(i) == r_head_q)))
                    rs1_busy = 1'b1;
                if ((r_rd_q[i] == rs2_addr) && (rs2_addr != '0) &&
                    !(w_byp2 && (c_pw'(i) == r_head_q)))
                    rs2_busy = 1'b1;
            end
        end
    end

    always_comb begin
        w_head_d       = r_head_q;
        w_tail_d       = r_tail_q;
        w_count_d      = r_count_q;
        w_vld_d        = r_vld_q;
        w_retire_d     = w_commit;
        w_retire_cnt_d = r_retire_cnt_q;
        if (w_commit) begin
            w_head_d          = f_inc(r_head_q);
            w_vld_d[r_head_q] = 1'b0;
            w_retire_cnt_d    = r_retire_cnt_q + 64'd1;
        end
        if (w_push) begin
            w_tail_d          = f_inc(r_tail_q);
            w_vld_d[r_tail_q] = 1'b1;
        end
        unique case ({w_push, w_commit})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_q       <= '0;
            r_tail_q       <= '0;
            r_count_q      <= '0;
            r_vld_q        <= '0;
            r_retire_q     <= 1'b0;
            r_retire_cnt_q <= '0;
        end else begin
            r_head_q       <= w_head_d;
            r_tail_q       <= w_tail_d;
            r_count_q      <= w_count_d;
            r_vld_q        <= w_vld_d;
            r_retire_q     <= w_retire_d;
            r_retire_cnt_q <= w_retire_cnt_d;
        end
    end

    // Payload needs no reset: r_vld_q and r_count_q qualify every use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data_q[r_tail_q] <= w_sel_data;
            r_wen_q[r_tail_q]  <= in_wen;
            r_rd_q[r_tail_q]   <= in_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_rf_q[i] <= '0;
        end else if (w_commit && w_head_wen && (w_head_rd != '0)) begin
            r_rf_q[w_head_rd] <= w_head_data;
        end
    end

    assign retire     = r_retire_q;
    assign retire_cnt = r_retire_cnt_q;

endmodule
`default_nettype wire

// File: doc/wbu_pipe.md
# wbu_pipe

Parametrised, handshaked writeback stage for the NPC core, successor to the multi-cycle writeback unit. It accepts retiring results from the LSU over a valid/ready interface and buffers them in a DEPTH-entry in-order queue. It selects the writeback source per entry, commits to an internal register file with x0 hardwired to zero, and serves the IDU's two combinational read ports, with optional same-cycle bypass and per-port hazard flags. A `hold` input freezes commits for debug halt, and a retire counter counts committed instructions.

## Interface
- `XLEN`, 32: data width of register file and all data ports.
- `NREG`, 32: architectural register count, 32 or 16 (RV32E); `AW = $clog2(NREG)`.
- `DEPTH`, 2: result queue entries, 1..4.
- `BYPASS`, 1: 1 = reads see the entry committing this cycle; 0 = reads see the register file only.
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  LSU has a retiring result.
- `in_ready`  out  1  queue can accept this cycle.
- `in_alu`  in  XLEN  ALU result.
- `in_lsu`  in  XLEN  load data.
- `in_csr`  in  XLEN  CSR old value.
- `in_sel`  in  2  source: 00 ALU, 01 LSU, 10 CSR, 11 ALU.
- `in_wen`  in  1  entry writes rd.
- `in_rd`  in  AW  destination register.
- `hold`  in  1  suppress commit this cycle.
- `rs1_addr`, `rs2_addr`  in  AW  IDU read addresses.
- `rs1_data`, `rs2_data`  out  XLEN  read data, combinational.
- `rs1_busy`, `rs2_busy`  out  1  address has an uncommitted pending write.
- `retire`  out  1  an entry committed this cycle (registered pulse).
- `retire_cnt`  out  64  total committed entries.

## Operation
- Queue: circular buffer, head/tail pointers, `count` 0..DEPTH. Each entry stores the mux-selected data (selection done at accept time), `wen`, and `rd`.
- Accept: `in_valid && in_ready` pushes at tail. `in_ready = (count < DEPTH)`. It is registered-state-based and is not raised by a commit in the same cycle, so there is no combinational ready path.
- Commit: when `count > 0 && !hold`, head pops. If its `wen` is set and `rd != 0`, regfile[rd] takes its data at the edge. Entries with `wen = 0` still pop and still count as retired.
- Simultaneous push and pop: count unchanged, both pointers advance; wrap modulo DEPTH.
- x0: never written; reads of address 0 return 0 and busy = 0.
- Read data: when `BYPASS=1`, a commit is active, the head writes, and head.rd equals rsN_addr (nonzero), rsN_data is the head data. Otherwise rsN_data is regfile[rsN_addr].
- Busy: rsN_busy = 1 if any valid writing entry targets rsN_addr, excluding the head when it is bypassed this cycle.
- retire_cnt increments by 1 per commit; it wraps at 2^64.
- `in_rd` values at or above NREG are masked to AW bits; the source is required to keep them in range.

## Timing
- Reset: queue emptied (count 0, pointers 0), all registers 0, `in_ready` 1, `retire` 0, `retire_cnt` 0, busy 0. Reset mid-operation drops all queued entries without commit.
- Latency: an entry accepted at edge N commits at edge N+1 at the earliest, when the queue was empty and hold is low.
  - Regfile reads show the value from cycle N+1 onward.
  - With BYPASS=1, reads show it combinationally during cycle N (after edge N, before edge N+1).
- `retire` is high for the cycle following each commit edge.
- `hold` high: no pop and no regfile write. Accepts continue until full, then `in_ready` drops. Releasing hold resumes one commit per cycle.
- Throughput: 1 entry/cycle sustained when `DEPTH >= 2`. When `DEPTH = 1`, the registered ready limits it to 1 entry/2 cycles.

## Test plan
- Reset, then push ALU 0x0000_1234 to x5 with sel 00. Required: x5 = 0x1234 one edge later, `retire` pulse, `retire_cnt` = 1.
- Push to x0 with data 0xFFFF_FFFF. Required: rs1 addr 0 reads 0, busy 0, `retire_cnt` increments.
- BYPASS=1: push LSU 0xDEAD_BEEF to x7 with rs1_addr=7. Required: rs1_data = 0xDEADBEEF and rs1_busy = 0 in the commit cycle. Repeat with BYPASS=0: old value and busy = 1 that cycle, new value next cycle.
- Hold high, push 3 entries with DEPTH=2. Required: `in_ready` drops after 2 accepts and no regfile change. After hold release, commits occur in order over 2 cycles.
- Back-to-back pushes to the same rd (x3 = 1, then x3 = 2) with DEPTH=2. Required: final x3 = 2, and busy is held until the last commit.
- Assert rst with 2 entries queued. Required: count 0, no commit, registers 0, `retire_cnt` 0 the cycle after.
